tri_assembler: RTL and testbench

//  Sits between tri_proj and rasterizer. Groups the serial projected-vertex stream
//  (one x/y/z per valid beat, 3 beats per facet) into whole screen-space triangles.

---
 rtl/tri_pkg.sv | 45 ++++
 rtl/tri_fifo.sv | 66 ++++++
 rtl/tri_assembler.sv | 212 +++++++++++++++++++++
 tb/tb_tri_assembler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle assembly path.
//   COORD_W  : width of one projected coordinate (matches tri_proj output)
//   AREA_W   : signed width of the doubled signed-area term used for back-face culling
//   vertex_t : packed {x, y, z}, x in the most significant bits
//   tri_t    : three vertices, [0] = first vertex of the facet
//   vidx_e   : vertex index within the facet being assembled
package tri_pkg;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned AREA_W  = 2 * COORD_W + 2;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vertex_t;

    typedef vertex_t [2:0] tri_t;

    typedef enum logic [1:0] {
        V0,
        V1,
        V2
    } vidx_e;

    // Doubled signed area (x2-x1)*(y3-y1) - (x3-x1)*(y2-y1).
    // Coordinates are unsigned; everything is widened to AREA_W before subtracting,
    // which is enough to hold the full-range result without overflow.
    function automatic logic signed [AREA_W-1:0] tri_area(vertex_t a, vertex_t b, vertex_t c);
        logic signed [AREA_W-1:0] ax, ay, bx, by, cx, cy;
        logic signed [AREA_W-1:0] dx21, dy31, dx31, dy21;
        ax   = {{(AREA_W-COORD_W){1'b0}}, a.x};
        ay   = {{(AREA_W-COORD_W){1'b0}}, a.y};
        bx   = {{(AREA_W-COORD_W){1'b0}}, b.x};
        by   = {{(AREA_W-COORD_W){1'b0}}, b.y};
        cx   = {{(AREA_W-COORD_W){1'b0}}, c.x};
        cy   = {{(AREA_W-COORD_W){1'b0}}, c.y};
        dx21 = bx - ax;
        dy31 = cy - ay;
        dx31 = cx - ax;
        dy21 = by - ay;
        return (dx21 * dy31) - (dx31 * dy21);
    endfunction

endpackage

// File: rtl/tri_fifo.sv
// Synchronous show-ahead FIFO for assembled triangles.
// The head entry is visible on rdata whenever empty is low; pop advances it.
// Read/write pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk    in   clock, posedge
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write wdata (ignored when full unless a pop happens in the same cycle)
//   wdata  in   entry to write
//   pop    in   drop the head entry (ignored when empty)
//   rdata  out  head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held
module tri_fifo
    import tri_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = tri_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    T            mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is still safe.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/tri_assembler.sv
// Triangle assembler: groups the serial projected-vertex stream (three beats per facet)
// into screen-space triangles, queues them and hands them to the rasterizer with a
// valid/ready handshake. The end-of-object marker is forwarded after the last queued
// triangle of the object has been consumed.
//
// Build option: define BACKFACE_CULL_EN to drop clockwise/degenerate triangles
// (signed area <= 0) and count them on cull_count_out. Without it every triangle is
// queued and cull_count_out is tied to zero.
//
// Ports:
//   clk_in          in   clock, posedge
//   rst_in          in   synchronous active-high reset
//   valid_in        in   vertex beat valid
//   x_in/y_in/z_in  in   projected vertex coordinates
//   obj_done_in     in   1-cycle pulse: object fully sent
//   ready_out       out  vertex beat accepted when valid_in & ready_out
//   vert1..3_out    out  head triangle vertices, packed {x, y, z}
//   valid_tri_out   out  head triangle valid
//   ready_in        in   rasterizer takes the head triangle when valid_tri_out & ready_in
//   obj_done_out    out  1-cycle end-of-object pulse, in order after the last triangle
//   tri_count_out   out  triangles queued since reset (saturating)
//   cull_count_out  out  triangles culled since reset (saturating)
//   partial_err     out  sticky: object ended in the middle of a triangle
module tri_assembler
    import tri_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [COORD_W-1:0]   x_in,
    input  logic [COORD_W-1:0]   y_in,
    input  logic [COORD_W-1:0]   z_in,
    input  logic                 obj_done_in,
    output logic                 ready_out,
    output logic [3*COORD_W-1:0] vert1_out,
    output logic [3*COORD_W-1:0] vert2_out,
    output logic [3*COORD_W-1:0] vert3_out,
    output logic                 valid_tri_out,
    input  logic                 ready_in,
    output logic                 obj_done_out,
    output logic [CNT_W-1:0]     tri_count_out,
    output logic [CNT_W-1:0]     cull_count_out,
    output logic                 partial_err
);

    vidx_e      idx_q;
    vidx_e      idx_d;
    vidx_e      idx_beat;
    vertex_t    h0_q;
    vertex_t    h1_q;
    vertex_t    beat_v;
    tri_t       tri_new;
    tri_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       beat_acc;
    logic       complete;
    logic       cull;
    logic       push;
    logic       pop;
    logic       obj_fire;
    logic       obj_pend_q;
    logic       obj_pend_d;
    logic       partial_err_q;
    logic [CNT_W-1:0] tri_cnt_q;

    assign beat_v  = '{x: x_in, y: y_in, z: z_in};
    assign tri_new = '{2: beat_v, 1: h1_q, 0: h0_q};

    // ---------------------------------------------------------------------------------------
    // Vertex index FSM
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_q <= V0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // An end-of-object pulse coinciding with a beat lets the beat land first, then
    // forces the index back to V0; idx_beat is the index after the beat alone.
    always_comb begin
        idx_beat = idx_q;
        if (beat_acc) begin
            unique case (idx_q)
                V0:      idx_beat = V1;
                V1:      idx_beat = V2;
                default: idx_beat = V0;
            endcase
        end
        idx_d = idx_beat;
        if (obj_done_in) begin
            idx_d = V0;
        end
    end

    // Only the closing beat needs FIFO space; ready never depends on ready_in.
    always_comb begin
        ready_out = (idx_q != V2) | ~fifo_full;
        complete  = beat_acc & (idx_q == V2);
    end

    assign beat_acc = valid_in & ready_out;

    // ---------------------------------------------------------------------------------------
    // Hold registers for the first two vertices of the facet
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            h0_q <= '0;
            h1_q <= '0;
        end else if (beat_acc) begin
            if (idx_q == V0) begin
                h0_q <= beat_v;
            end
            if (idx_q == V1) begin
                h1_q <= beat_v;
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Back-face culling
    // ---------------------------------------------------------------------------------------
`ifdef BACKFACE_CULL_EN
    logic signed [AREA_W-1:0] area;
    logic [CNT_W-1:0]         cull_cnt_q;

    assign area = tri_area(h0_q, h1_q, beat_v);
    // Negative or zero area: clockwise or degenerate.
    assign cull = complete & (area[AREA_W-1] | (area == '0));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cull_cnt_q <= '0;
        end else if (cull && (cull_cnt_q != {CNT_W{1'b1}})) begin
            cull_cnt_q <= cull_cnt_q + CNT_W'(1);
        end
    end

    assign cull_count_out = cull_cnt_q;
`else
    assign cull           = 1'b0;
    assign cull_count_out = '0;
`endif

    assign push = complete & ~cull;
    assign pop  = ~fifo_empty & ready_in;

    // ---------------------------------------------------------------------------------------
    // Triangle queue
    // ---------------------------------------------------------------------------------------
    tri_fifo #(
        .DEPTH (DEPTH),
        .T     (tri_t)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (push),
        .wdata (tri_new),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign valid_tri_out = ~fifo_empty;
    assign vert1_out     = head[0];
    assign vert2_out     = head[1];
    assign vert3_out     = head[2];

    // ---------------------------------------------------------------------------------------
    // End-of-object sequencing and error flag
    // ---------------------------------------------------------------------------------------
    // The marker waits until the queue is drained and no triangle is entering it, so it
    // always trails the object's last triangle. Repeated markers while pending merge.
    assign obj_fire     = obj_pend_q & fifo_empty & ~push;
    assign obj_pend_d   = obj_done_in | (obj_pend_q & ~obj_fire);
    assign obj_done_out = obj_fire;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            obj_pend_q    <= 1'b0;
            partial_err_q <= 1'b0;
        end else begin
            obj_pend_q <= obj_pend_d;
            if (obj_done_in && (idx_beat != V0)) begin
                partial_err_q <= 1'b1;
            end
        end
    end

    assign partial_err = partial_err_q;

    // ---------------------------------------------------------------------------------------
    // Statistics
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tri_cnt_q <= '0;
        end else if (push && (tri_cnt_q != {CNT_W{1'b1}})) begin
            tri_cnt_q <= tri_cnt_q + CNT_W'(1);
        end
    end

    assign tri_count_out = tri_cnt_q;

endmodule

// File: tb/tb_tri_assembler.sv
// Directed bench for tri_assembler: reset state, single triangle latency, FIFO full
// back-pressure and ordering, partial-triangle end-of-object, end-of-object ordering,
// culling (or its absence in the default build) and mid-stream reset.
module tb_tri_assembler;

    localparam int unsigned CW = 9;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          valid_in;
    logic [CW-1:0] x_in, y_in, z_in;
    logic          obj_done_in;
    logic          ready_out;
    logic [3*CW-1:0] vert1_out, vert2_out, vert3_out;
    logic          valid_tri_out;
    logic          ready_in;
    logic          obj_done_out;
    logic [15:0]   tri_count_out;
    logic [15:0]   cull_count_out;
    logic          partial_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tri_assembler #(
        .DEPTH (8),
        .CNT_W (16)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .z_in           (z_in),
        .obj_done_in    (obj_done_in),
        .ready_out      (ready_out),
        .vert1_out      (vert1_out),
        .vert2_out      (vert2_out),
        .vert3_out      (vert3_out),
        .valid_tri_out  (valid_tri_out),
        .ready_in       (ready_in),
        .obj_done_out   (obj_done_out),
        .tri_count_out  (tri_count_out),
        .cull_count_out (cull_count_out),
        .partial_err    (partial_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3*CW-1:0] pk(input int x, input int y, input int z);
        return {CW'(x), CW'(y), CW'(z)};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on falling edges.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int x, input int y, input int z);
        valid_in = 1'b1;
        x_in     = CW'(x);
        y_in     = CW'(y);
        z_in     = CW'(z);
        next_cycle();
        valid_in = 1'b0;
    endtask

    task automatic send_obj_done();
        obj_done_in = 1'b1;
        next_cycle();
        obj_done_in = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int popped;
        int pops, last_pop, done_at, n_done;
        logic do_pop, acc;

        rst_in      = 1'b1;
        valid_in    = 1'b0;
        x_in        = '0;
        y_in        = '0;
        z_in        = '0;
        obj_done_in = 1'b0;
        ready_in    = 1'b0;
        next_cycle();
        next_cycle();
        rst_in = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid_tri", valid_tri_out, 0);
        check_eq("rst_ready_out", ready_out, 1);
        check_eq("rst_obj_done", obj_done_out, 0);
        check_eq("rst_tri_count", tri_count_out, 0);
        check_eq("rst_cull_count", cull_count_out, 0);
        check_eq("rst_partial_err", partial_err, 0);
        next_cycle();

        // 1: single triangle, visible the cycle after the closing beat, for one cycle
        ready_in = 1'b1;
        send_beat(10, 10, 5);
        send_beat(50, 10, 5);
        send_beat(10, 50, 5);
        @(negedge clk);
        check_eq("t1_valid", valid_tri_out, 1);
        check_eq("t1_vert1", vert1_out, pk(10, 10, 5));
        check_eq("t1_vert2", vert2_out, pk(50, 10, 5));
        check_eq("t1_vert3", vert3_out, pk(10, 50, 5));
        next_cycle();
        @(negedge clk);
        check_eq("t1_valid_drop", valid_tri_out, 0);
        check_eq("t1_tri_count", tri_count_out, 1);
        next_cycle();

        // 2: fill the FIFO, block on the 9th closing beat, drain in order
        ready_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_beat(10, 10, 3 * k);
            send_beat(50, 10, 3 * k + 1);
            send_beat(10, 50, 3 * k + 2);
        end
        valid_in = 1'b1; x_in = 10; y_in = 10; z_in = 24;
        @(negedge clk);
        check_eq("t2_v0_ready", ready_out, 1);
        next_cycle();
        valid_in = 1'b1; x_in = 50; y_in = 10; z_in = 25;
        @(negedge clk);
        check_eq("t2_v1_ready", ready_out, 1);
        next_cycle();
        valid_in = 1'b1; x_in = 10; y_in = 50; z_in = 26;
        @(negedge clk);
        check_eq("t2_v2_blocked", ready_out, 0);
        check_eq("t2_full_valid", valid_tri_out, 1);
        ready_in = 1'b1;
        popped   = 0;
        for (int i = 0; i < 40 && popped < 9; i++) begin
            do_pop = valid_tri_out & ready_in;
            acc    = valid_in & ready_out;
            if (do_pop) begin
                check_eq($sformatf("t2_pop%0d_vert1", popped), vert1_out,
                         pk(10, 10, 3 * popped));
                check_eq($sformatf("t2_pop%0d_vert3", popped), vert3_out,
                         pk(10, 50, 3 * popped + 2));
                popped++;
            end
            next_cycle();
            if (acc) valid_in = 1'b0;
            @(negedge clk);
        end
        check_eq("t2_pop_count", popped, 9);
        check_eq("t2_tri_count", tri_count_out, 10);
        next_cycle();

        // 3: end of object mid-triangle
        send_beat(100, 100, 1);
        send_beat(200, 100, 1);
        send_obj_done();
        @(negedge clk);
        check_eq("t3_partial_err", partial_err, 1);
        check_eq("t3_obj_done_pulse", obj_done_out, 1);
        check_eq("t3_nothing_pushed", valid_tri_out, 0);
        next_cycle();
        @(negedge clk);
        check_eq("t3_obj_done_end", obj_done_out, 0);
        next_cycle();
        send_beat(20, 20, 1);
        send_beat(60, 20, 2);
        send_beat(20, 60, 3);
        @(negedge clk);
        check_eq("t3_fresh_valid", valid_tri_out, 1);
        check_eq("t3_fresh_vert1", vert1_out, pk(20, 20, 1));
        check_eq("t3_fresh_vert3", vert3_out, pk(20, 60, 3));
        check_eq("t3_tri_count", tri_count_out, 11);
        next_cycle();

        // 4: end-of-object marker trails the third pop by exactly one cycle
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_beat(10, 10, 40 + k);
            send_beat(50, 10, 40 + k);
            send_beat(10, 50, 40 + k);
        end
        send_obj_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t4_hold_no_done%0d", i), obj_done_out, 0);
            next_cycle();
        end
        ready_in = 1'b1;
        pops     = 0;
        last_pop = -1;
        done_at  = -1;
        n_done   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obj_done_out) begin
                n_done++;
                done_at = i;
            end
            if (valid_tri_out && ready_in) begin
                pops++;
                last_pop = i;
            end
            next_cycle();
        end
        check_eq("t4_pops", pops, 3);
        check_eq("t4_done_pulses", n_done, 1);
        check_eq("t4_done_after_last_pop", done_at, last_pop + 1);
        check_eq("t4_tri_count", tri_count_out, 14);

        // 5: clockwise and collinear triangles
        send_beat(10, 10, 0);
        send_beat(10, 50, 0);
        send_beat(50, 10, 0);
        send_beat(0, 0, 0);
        send_beat(5, 5, 0);
        send_beat(9, 9, 0);
        next_cycle();
        @(negedge clk);
`ifdef BACKFACE_CULL_EN
        check_eq("t5_cull_count", cull_count_out, 2);
        check_eq("t5_tri_count", tri_count_out, 14);
`else
        check_eq("t5_cull_count", cull_count_out, 0);
        check_eq("t5_tri_count", tri_count_out, 16);
`endif
        next_cycle();

        // 6: reset with the FIFO half full and a vertex held
        ready_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_beat(10, 10, 60 + k);
            send_beat(50, 10, 60 + k);
            send_beat(10, 50, 60 + k);
        end
        send_beat(300, 300, 99);
        @(negedge clk);
        check_eq("t6_pre_valid", valid_tri_out, 1);
        next_cycle();
        rst_in = 1'b1;
        next_cycle();
        rst_in = 1'b0;
        @(negedge clk);
        check_eq("t6_valid", valid_tri_out, 0);
        check_eq("t6_tri_count", tri_count_out, 0);
        check_eq("t6_cull_count", cull_count_out, 0);
        check_eq("t6_partial_err", partial_err, 0);
        check_eq("t6_ready_out", ready_out, 1);
        next_cycle();
        ready_in = 1'b1;
        send_beat(30, 30, 7);
        send_beat(70, 30, 8);
        send_beat(30, 70, 9);
        @(negedge clk);
        check_eq("t6_clean_valid", valid_tri_out, 1);
        check_eq("t6_clean_vert1", vert1_out, pk(30, 30, 7));
        check_eq("t6_clean_vert2", vert2_out, pk(70, 30, 8));
        check_eq("t6_clean_vert3", vert3_out, pk(30, 70, 9));
        check_eq("t6_clean_count", tri_count_out, 1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
